video_mem_arbiter: RTL and testbench
====================================

VIDEO_MEM_ARBITER -- requirements
Module: video_mem_arbiter

Interface
REQ-001 SHALL have parameters: DISPLAY_WIDTH, 240, pixels per line; DISPLAY_HEIGHT, 320, lines; SPRITE_SIZE, 8, sprite edge (power of 2, divides both dimensions); WIDTH_BITS, $clog2(DISPLAY_WIDTH), x width; HEIGHT_BITS, $clog2(DISPLAY_HEIGHT), y width.
REQ-002 SHALL have derived constants: TILE_MEM_SIZE = (W/S)*(H/S) = 1200; tile address 11 bits; sprite address 14 bits (256*S*S).
REQ-003 SHALL have ports (one clock; reset asynchronous, active-low):
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
in_display_region  in  1  1 = display owns memory; SPI writes held off
pix_req  in  1  pixel fetch request
pix_x  in  WIDTH_BITS  pixel column
pix_y  in  HEIGHT_BITS  pixel row
pix_ready  out  1  pixel request accepted this cycle when high with pix_req
pix_valid  out  1  one-cycle pulse, pix_data valid
pix_data  out  16  RGB565 pixel
wr_valid  in  1  SPI word available
wr_word  in  32  [31] 1=tile/0=sprite, [30:16] address, [15:0] data
wr_ready  out  1  SPI word consumed this cycle when high with wr_valid
tile_addr  out  11  tile memory address
tile_rd_data  in  8  tile read data, synchronous, 1-cycle latency
tile_wr_en  out  1  tile write strobe
tile_wr_data  out  8  tile write data (wr_word[7:0])
sprite_addr  out  14  sprite memory address
sprite_rd_data  in  16  sprite read data, synchronous, 1-cycle latency
sprite_wr_en  out  1  sprite write strobe
sprite_wr_data  out  16  sprite write data
drop_count  out  8  count of rejected out-of-range writes

Function
REQ-004 SHALL implement FSM states IDLE, TILE_WAIT, SPR_ADDR, SPR_WAIT, PIX_OUT, WRITE; reset state IDLE.
REQ-005 SHALL drive pix_ready = (state==IDLE) & in_display_region & reset; wr_ready = (state==IDLE) & ~in_display_region & reset.
REQ-006 SHALL, on pix_req & pix_ready at edge E0, latch x/y, register tile_addr = x/S + (y/S)*(W/S), go TILE_WAIT.
REQ-007 SHALL sequence TILE_WAIT -> SPR_ADDR (register sprite_addr = tile_rd_data*S*S + (y%S)*S + x%S) -> SPR_WAIT -> PIX_OUT (register pix_data = sprite_rd_data, pix_valid=1) -> IDLE.
REQ-008 SHALL assert pix_valid for exactly one cycle, starting after the 4th edge following E0; pix_data held until next pix_valid.
REQ-009 SHALL, for pix_x >= W or pix_y >= H, run the same state sequence with tile_addr=0 and return pix_data=0x0000 at the same latency.
REQ-010 SHALL, on wr_valid & wr_ready, register address/data, go WRITE; in WRITE assert exactly one of tile_wr_en/sprite_wr_en for one cycle, then IDLE (max one write per 2 cycles).
REQ-011 SHALL reject tile writes with address >= 1200 and sprite writes with address bit 14 set: word consumed, no strobe, drop_count += 1, saturating at 255.
REQ-012 SHALL complete an in-progress pixel fetch or write regardless of in_display_region changes; new grants use its value in IDLE.
REQ-013 SHALL never assert a write strobe in states other than WRITE; never assert both strobes together.

Reset
REQ-014 SHALL, while reset low, force state IDLE, pix_valid=0, pix_data=0, all addresses/write data=0, both strobes=0, drop_count=0, both ready outputs=0, asynchronously.
REQ-015 SHALL abort any in-flight fetch/write on reset assertion with no further pix_valid or strobe for it.

Verification
REQ-016 Fetch: region=1, tile_mem[31]=5, sprite_mem[5*64+9]=0xF800, pix_req x=9,y=9 -> tile_addr=31, sprite_addr=329, pix_valid 4 edges later, pix_data=0xF800.
REQ-017 Write: region=0, wr_word=0x8004_0007 -> tile_addr=4, tile_wr_en one cycle, tile_wr_data=0x07; wr_ready low in WRITE cycle.
REQ-018 Range: wr_word tile addr 1200, then sprite addr 0x4000 -> no strobes, drop_count=2; 300 such words -> drop_count=255.
REQ-019 Contention: region=1, pix_req and wr_valid both high -> pixel granted, wr_ready=0 until region=0; region drops mid-fetch -> fetch completes with pix_valid.
REQ-020 Reset: assert reset in SPR_WAIT -> pix_valid never pulses, outputs reach reset values same cycle; release -> pix_ready=1 next cycle with region=1.

Source files
------------

// File: rtl/video_mem_arbiter_if.sv
// Pixel-fetch, SPI-write and tile/sprite memory signals around the video memory arbiter.
// Latency: none; this is a plain signal bundle.
// Backpressure: pix_ready / wr_ready gate the pixel and SPI request channels.
interface video_mem_arbiter_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 9
);
    logic                   in_display_region;
    logic                   pix_req;
    logic [WIDTH_BITS-1:0]  pix_x;
    logic [HEIGHT_BITS-1:0] pix_y;
    logic                   pix_ready;
    logic                   pix_valid;
    logic [15:0]            pix_data;
    logic                   wr_valid;
    logic [31:0]            wr_word;
    logic                   wr_ready;
    logic [10:0]            tile_addr;
    logic [7:0]             tile_rd_data;
    logic                   tile_wr_en;
    logic [7:0]             tile_wr_data;
    logic [13:0]            sprite_addr;
    logic [15:0]            sprite_rd_data;
    logic                   sprite_wr_en;
    logic [15:0]            sprite_wr_data;
    logic [7:0]             drop_count;

    // Arbiter side: owns the memory address/strobe buses and the ready/valid outputs.
    modport master (
        input  in_display_region, pix_req, pix_x, pix_y, wr_valid, wr_word,
               tile_rd_data, sprite_rd_data,
        output pix_ready, pix_valid, pix_data, wr_ready, tile_addr, tile_wr_en,
               tile_wr_data, sprite_addr, sprite_wr_en, sprite_wr_data, drop_count
    );

    // Environment side: requesters plus the two synchronous memories.
    modport slave (
        output in_display_region, pix_req, pix_x, pix_y, wr_valid, wr_word,
               tile_rd_data, sprite_rd_data,
        input  pix_ready, pix_valid, pix_data, wr_ready, tile_addr, tile_wr_en,
               tile_wr_data, sprite_addr, sprite_wr_en, sprite_wr_data, drop_count
    );
endinterface

// File: rtl/video_mem_arbiter.sv
// Arbitrates tile/sprite memory between display pixel fetches and SPI writes.
// Latency: pixel fetch -> pix_valid 4 edges after grant; write strobe 1 cycle after grant.
// Backpressure: one request at a time; pix_ready/wr_ready only high in IDLE, chosen by in_display_region.
module video_mem_arbiter #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int SPRITE_SIZE    = 8,
    parameter int WIDTH_BITS     = $clog2(DISPLAY_WIDTH),
    parameter int HEIGHT_BITS    = $clog2(DISPLAY_HEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    video_mem_arbiter_if.master bus
);
    localparam int SB            = $clog2(SPRITE_SIZE);
    localparam int TILE_COLS     = DISPLAY_WIDTH / SPRITE_SIZE;
    localparam int TILE_MEM_SIZE = TILE_COLS * (DISPLAY_HEIGHT / SPRITE_SIZE);
    localparam int TILE_AW       = 11;
    localparam int SPR_AW        = 14;

    typedef enum logic [2:0] {IDLE, TILE_WAIT, SPR_ADDR, SPR_WAIT, PIX_OUT, WRITE} state_t;

    state_t               state_q, state_d;
    logic [SB-1:0]        x_lo_q, x_lo_d;
    logic [SB-1:0]        y_lo_q, y_lo_d;
    logic                 oor_q, oor_d;
    logic [TILE_AW-1:0]   tile_addr_q, tile_addr_d;
    logic [SPR_AW-1:0]    sprite_addr_q, sprite_addr_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [15:0]          pix_data_q, pix_data_d;
    logic                 tile_wr_en_q, tile_wr_en_d;
    logic [7:0]           tile_wr_data_q, tile_wr_data_d;
    logic                 sprite_wr_en_q, sprite_wr_en_d;
    logic [15:0]          sprite_wr_data_q, sprite_wr_data_d;
    logic [7:0]           drop_count_q, drop_count_d;

    logic [WIDTH_BITS-1:0]  px;
    logic [HEIGHT_BITS-1:0] py;
    logic                   pix_ready_w, wr_ready_w;
    logic                   req_oor;
    logic [TILE_AW-1:0]     req_tile_idx;
    logic [SPR_AW-1:0]      fetch_spr_addr;
    logic [14:0]            wr_addr;
    logic                   wr_is_tile, wr_ok;

    assign px = bus.pix_x;
    assign py = bus.pix_y;

    // Grants are only offered from IDLE; the region flag picks which requester may win.
    assign pix_ready_w = (state_q == IDLE) & bus.in_display_region  & reset;
    assign wr_ready_w  = (state_q == IDLE) & ~bus.in_display_region & reset;

    // Off-screen coordinates still walk the full sequence so latency is constant.
    assign req_oor        = (int'(px) >= DISPLAY_WIDTH) | (int'(py) >= DISPLAY_HEIGHT);
    assign req_tile_idx   = TILE_AW'(int'(px >> SB) + int'(py >> SB) * TILE_COLS);
    assign fetch_spr_addr = SPR_AW'(int'(bus.tile_rd_data) * (SPRITE_SIZE * SPRITE_SIZE)
                                  + int'(y_lo_q) * SPRITE_SIZE + int'(x_lo_q));

    // SPI word: bit 31 selects tile memory, bits 30:16 address, bits 15:0 data.
    assign wr_is_tile = bus.wr_word[31];
    assign wr_addr    = bus.wr_word[30:16];
    assign wr_ok      = wr_is_tile ? (int'(wr_addr) < TILE_MEM_SIZE) : ~wr_addr[14];

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d          = state_q;
        x_lo_d           = x_lo_q;
        y_lo_d           = y_lo_q;
        oor_d            = oor_q;
        tile_addr_d      = tile_addr_q;
        sprite_addr_d    = sprite_addr_q;
        pix_valid_d      = 1'b0;
        pix_data_d       = pix_data_q;
        tile_wr_en_d     = 1'b0;
        tile_wr_data_d   = tile_wr_data_q;
        sprite_wr_en_d   = 1'b0;
        sprite_wr_data_d = sprite_wr_data_q;
        drop_count_d     = drop_count_q;
        case (state_q)
            IDLE: begin
                if (bus.pix_req & pix_ready_w) begin
                    x_lo_d      = px[SB-1:0];
                    y_lo_d      = py[SB-1:0];
                    oor_d       = req_oor;
                    tile_addr_d = req_oor ? '0 : req_tile_idx;
                    state_d     = TILE_WAIT;
                end else if (bus.wr_valid & wr_ready_w) begin
                    // Rejected words are consumed but raise no strobe.
                    if (wr_ok && wr_is_tile) begin
                        tile_addr_d    = wr_addr[TILE_AW-1:0];
                        tile_wr_data_d = bus.wr_word[7:0];
                        tile_wr_en_d   = 1'b1;
                    end else if (wr_ok) begin
                        sprite_addr_d    = wr_addr[SPR_AW-1:0];
                        sprite_wr_data_d = bus.wr_word[15:0];
                        sprite_wr_en_d   = 1'b1;
                    end else if (drop_count_q != 8'hFF) begin
                        drop_count_d = drop_count_q + 8'd1;
                    end
                    state_d = WRITE;
                end
            end
            TILE_WAIT: state_d = SPR_ADDR;
            SPR_ADDR: begin
                sprite_addr_d = fetch_spr_addr;
                state_d       = SPR_WAIT;
            end
            SPR_WAIT: state_d = PIX_OUT;
            PIX_OUT: begin
                pix_data_d  = oor_q ? 16'h0000 : bus.sprite_rd_data;
                pix_valid_d = 1'b1;
                state_d     = IDLE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything and aborts any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            x_lo_q           <= '0;
            y_lo_q           <= '0;
            oor_q            <= 1'b0;
            tile_addr_q      <= '0;
            sprite_addr_q    <= '0;
            pix_valid_q      <= 1'b0;
            pix_data_q       <= '0;
            tile_wr_en_q     <= 1'b0;
            tile_wr_data_q   <= '0;
            sprite_wr_en_q   <= 1'b0;
            sprite_wr_data_q <= '0;
            drop_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            x_lo_q           <= x_lo_d;
            y_lo_q           <= y_lo_d;
            oor_q            <= oor_d;
            tile_addr_q      <= tile_addr_d;
            sprite_addr_q    <= sprite_addr_d;
            pix_valid_q      <= pix_valid_d;
            pix_data_q       <= pix_data_d;
            tile_wr_en_q     <= tile_wr_en_d;
            tile_wr_data_q   <= tile_wr_data_d;
            sprite_wr_en_q   <= sprite_wr_en_d;
            sprite_wr_data_q <= sprite_wr_data_d;
            drop_count_q     <= drop_count_d;
        end
    end

    assign bus.pix_ready      = pix_ready_w;
    assign bus.wr_ready       = wr_ready_w;
    assign bus.pix_valid      = pix_valid_q;
    assign bus.pix_data       = pix_data_q;
    assign bus.tile_addr      = tile_addr_q;
    assign bus.tile_wr_en     = tile_wr_en_q;
    assign bus.tile_wr_data   = tile_wr_data_q;
    assign bus.sprite_addr    = sprite_addr_q;
    assign bus.sprite_wr_en   = sprite_wr_en_q;
    assign bus.sprite_wr_data = sprite_wr_data_q;
    assign bus.drop_count     = drop_count_q;
endmodule

// File: tb/tb_video_mem_arbiter.sv
// Randomized bench for video_mem_arbiter with tile/sprite memory models and a reference model.
// Latency: checks pix_valid exactly 4 edges after grant and write strobes 1 cycle after grant.
// Backpressure: requests wait (bounded) for pix_ready / wr_ready before being presented.
module tb_video_mem_arbiter;
    localparam int W     = 240;
    localparam int H     = 320;
    localparam int S     = 8;
    localparam int TCOLS = W / S;
    localparam int TSIZE = TCOLS * (H / S);

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memories seen by the DUT (written only by the memory model process).
    logic [7:0]  tile_mem [0:2047];
    logic [15:0] spr_mem  [0:16383];
    bit          mem_init_done = 1'b0;

    // Reference contents and drop counter, updated from the write rules.
    logic [7:0]  m_tile [0:2047];
    logic [15:0] m_spr  [0:16383];
    int          m_drop;

    video_mem_arbiter_if #(.WIDTH_BITS(8), .HEIGHT_BITS(9)) bus();

    video_mem_arbiter #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .SPRITE_SIZE   (S),
        .WIDTH_BITS    (8),
        .HEIGHT_BITS   (9)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tile_seed(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    function automatic logic [15:0] spr_seed(input int i);
        return 16'(i * 40503 + 12345);
    endfunction

    // Synchronous 1-cycle-latency memories with write strobes.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 2048; i++)  tile_mem[i] <= tile_seed(i);
            for (int i = 0; i < 16384; i++) spr_mem[i]  <= spr_seed(i);
            mem_init_done <= 1'b1;
        end else begin
            bus.tile_rd_data   <= tile_mem[bus.tile_addr];
            bus.sprite_rd_data <= spr_mem[bus.sprite_addr];
            if (bus.tile_wr_en)   tile_mem[bus.tile_addr]  <= bus.tile_wr_data;
            if (bus.sprite_wr_en) spr_mem[bus.sprite_addr] <= bus.sprite_wr_data;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit want_pix, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (want_pix ? bus.pix_ready : bus.wr_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            if (want_pix) chk_eq("pix_ready_timeout", 32'(bus.pix_ready), 1);
            else          chk_eq("wr_ready_timeout", 32'(bus.wr_ready), 1);
        end
    endtask

    // Expected result of a pixel fetch from the display/tile/sprite mapping rules.
    function automatic void exp_fetch(input int x, input int y, output int ta,
                                      output int sa, output int pd, output bit oor);
        oor = (x >= W) || (y >= H);
        if (oor) begin
            ta = 0;
            sa = 0;
            pd = 0;
        end else begin
            ta = x / S + (y / S) * TCOLS;
            sa = int'(m_tile[ta]) * S * S + (y % S) * S + (x % S);
            pd = int'(m_spr[sa]);
        end
    endfunction

    task automatic do_fetch(input int x, input int y);
        int ta, sa, pd;
        bit oor, ok;
        bus.in_display_region = 1'b1;
        wait_ready(1'b1, ok);
        if (!ok) return;
        exp_fetch(x, y, ta, sa, pd, oor);
        bus.pix_req = 1'b1;
        bus.pix_x   = 8'(x);
        bus.pix_y   = 9'(y);
        step();
        bus.pix_req = 1'b0;
        chk_eq("fetch_tile_addr", 32'(bus.tile_addr), ta);
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e == 2 && !oor) chk_eq("fetch_spr_addr", 32'(bus.sprite_addr), sa);
            if (e < 4) chk_eq("fetch_early_valid", 32'(bus.pix_valid), 0);
        end
        chk_eq("fetch_valid", 32'(bus.pix_valid), 1);
        chk_eq("fetch_data", 32'(bus.pix_data), pd);
        step();
        chk_eq("fetch_valid_pulse", 32'(bus.pix_valid), 0);
        chk_eq("fetch_data_hold", 32'(bus.pix_data), pd);
    endtask

    task automatic do_write(input logic [31:0] word);
        bit is_tile, good, ok;
        logic [14:0] a;
        bus.in_display_region = 1'b0;
        wait_ready(1'b0, ok);
        if (!ok) return;
        is_tile = word[31];
        a       = word[30:16];
        good    = is_tile ? (int'(a) < TSIZE) : (a[14] == 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_word  = word;
        step();
        bus.wr_valid = 1'b0;
        chk_eq("wr_ready_in_write", 32'(bus.wr_ready), 0);
        chk_eq("tile_wr_en", 32'(bus.tile_wr_en), 32'(is_tile && good));
        chk_eq("sprite_wr_en", 32'(bus.sprite_wr_en), 32'(!is_tile && good));
        if (is_tile && good) begin
            chk_eq("tile_wr_addr", 32'(bus.tile_addr), 32'(a[10:0]));
            chk_eq("tile_wr_data", 32'(bus.tile_wr_data), 32'(word[7:0]));
            m_tile[a[10:0]] = word[7:0];
        end else if (good) begin
            chk_eq("sprite_wr_addr", 32'(bus.sprite_addr), 32'(a[13:0]));
            chk_eq("sprite_wr_data", 32'(bus.sprite_wr_data), 32'(word[15:0]));
            m_spr[a[13:0]] = word[15:0];
        end else if (m_drop < 255) begin
            m_drop++;
        end
        chk_eq("drop_count", 32'(bus.drop_count), m_drop);
        step();
        chk_eq("strobe_end_tile", 32'(bus.tile_wr_en), 0);
        chk_eq("strobe_end_sprite", 32'(bus.sprite_wr_en), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x, y, ta, sa, pd;
        bit oor, ok;
        logic [31:0] w;

        for (int i = 0; i < 2048; i++)  m_tile[i] = tile_seed(i);
        for (int i = 0; i < 16384; i++) m_spr[i]  = spr_seed(i);
        m_drop = 0;
        rst_n                 = 1'b0;
        bus.in_display_region = 1'b1;
        bus.pix_req           = 1'b0;
        bus.pix_x             = '0;
        bus.pix_y             = '0;
        bus.wr_valid          = 1'b0;
        bus.wr_word           = '0;
        repeat (3) step();

        // Reset values.
        chk_eq("rst_pix_ready", 32'(bus.pix_ready), 0);
        chk_eq("rst_pix_valid", 32'(bus.pix_valid), 0);
        chk_eq("rst_pix_data", 32'(bus.pix_data), 0);
        chk_eq("rst_tile_addr", 32'(bus.tile_addr), 0);
        chk_eq("rst_sprite_addr", 32'(bus.sprite_addr), 0);
        chk_eq("rst_strobes", 32'({bus.tile_wr_en, bus.sprite_wr_en}), 0);
        chk_eq("rst_wr_data", 32'({bus.tile_wr_data, bus.sprite_wr_data}), 0);
        chk_eq("rst_drop", 32'(bus.drop_count), 0);
        bus.in_display_region = 1'b0;
        #1;
        chk_eq("rst_wr_ready", 32'(bus.wr_ready), 0);
        rst_n = 1'b1;
        bus.in_display_region = 1'b1;
        step();
        chk_eq("post_rst_pix_ready", 32'(bus.pix_ready), 1);

        // Directed write, fetch of written data, range rejection.
        do_write(32'h8004_0007);
        do_write({1'b1, 15'd31, 16'h0005});
        do_write({1'b0, 15'd329, 16'hF800});
        do_fetch(9, 9);
        chk_eq("fetch_9_9_data", 32'(bus.pix_data), 32'h0000_F800);
        do_write({1'b1, 15'd1200, 16'h0055});
        do_write({1'b0, 15'h4000, 16'h1234});
        chk_eq("drop_two", 32'(bus.drop_count), 2);

        // Off-screen fetches.
        do_fetch(240, 5);
        do_fetch(3, 320);
        do_fetch(255, 511);

        // Contention: pixel wins while region=1; region drops mid-fetch.
        bus.in_display_region = 1'b1;
        wait_ready(1'b1, ok);
        x = $urandom_range(0, W - 1);
        y = $urandom_range(0, H - 1);
        exp_fetch(x, y, ta, sa, pd, oor);
        bus.wr_word  = {1'b1, 15'd16, 16'h00AB};
        bus.wr_valid = 1'b1;
        bus.pix_req  = 1'b1;
        bus.pix_x    = 8'(x);
        bus.pix_y    = 9'(y);
        #1;
        chk_eq("cont_wr_ready", 32'(bus.wr_ready), 0);
        chk_eq("cont_pix_ready", 32'(bus.pix_ready), 1);
        step();
        bus.pix_req = 1'b0;
        bus.in_display_region = 1'b0;
        chk_eq("cont_tile_addr", 32'(bus.tile_addr), ta);
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e < 4) chk_eq("cont_wr_held", 32'(bus.wr_ready), 0);
            if (e < 4) chk_eq("cont_early_valid", 32'(bus.pix_valid), 0);
        end
        chk_eq("cont_valid", 32'(bus.pix_valid), 1);
        chk_eq("cont_data", 32'(bus.pix_data), pd);
        chk_eq("cont_wr_ready_after", 32'(bus.wr_ready), 1);
        step();
        bus.wr_valid = 1'b0;
        chk_eq("cont_tile_wr_en", 32'(bus.tile_wr_en), 1);
        chk_eq("cont_tile_wr_addr", 32'(bus.tile_addr), 16);
        m_tile[16] = 8'hAB;
        step();

        // Randomized mix of fetches and writes.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, W - 1);
                y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, H - 1);
                do_fetch(x, y);
            end else if ($urandom_range(0, 1) == 1) begin
                y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 32767) : $urandom_range(0, TSIZE - 1);
                w = {1'b1, 15'(y), 16'($urandom)};
                do_write(w);
            end else begin
                y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 32767) : $urandom_range(0, 16383);
                w = {1'b0, 15'(y), 16'($urandom)};
                do_write(w);
            end
        end

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) w = {1'b1, 15'($urandom_range(TSIZE, 32767)), 16'($urandom)};
            else            w = {1'b0, 1'b1, 14'($urandom), 16'($urandom)};
            do_write(w);
        end
        chk_eq("drop_saturated", 32'(bus.drop_count), 255);

        // Reset asserted while the fetch sits in SPR_WAIT.
        bus.in_display_region = 1'b1;
        wait_ready(1'b1, ok);
        bus.pix_req = 1'b1;
        bus.pix_x   = 8'd10;
        bus.pix_y   = 9'd10;
        step();
        bus.pix_req = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_eq("arst_pix_valid", 32'(bus.pix_valid), 0);
        chk_eq("arst_pix_data", 32'(bus.pix_data), 0);
        chk_eq("arst_tile_addr", 32'(bus.tile_addr), 0);
        chk_eq("arst_sprite_addr", 32'(bus.sprite_addr), 0);
        chk_eq("arst_pix_ready", 32'(bus.pix_ready), 0);
        chk_eq("arst_drop", 32'(bus.drop_count), 0);
        m_drop = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_eq("arst_no_valid", 32'(bus.pix_valid), 0);
        end
        rst_n = 1'b1;
        step();
        chk_eq("arst_release_ready", 32'(bus.pix_ready), 1);
        chk_eq("arst_release_valid", 32'(bus.pix_valid), 0);
        do_fetch(9, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
